// File: rtl/add_operand_seq.sv
// Operand sequencer for the ripple adder: captures A, then B and ADD/SUB, and registers the result.
// Optional macro ADD_SEQ_SIGNED_OVF_EN makes `flag` report signed overflow instead of carry/borrow.
module add_operand_seq #(
    parameter int unsigned width = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [width-1:0] sw,
    input  logic             op_sub,
    input  logic             load,
    input  logic             clear,
    output logic [width-1:0] add_a,
    output logic [width-1:0] add_b,
    output logic             add_c_in,
    input  logic [width-1:0] add_out,
    input  logic             add_overflow,
    output logic [width-1:0] result,
    output logic             flag,
    output logic             result_valid,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        StA    = 2'd0,
        StB    = 2'd1,
        StCalc = 2'd2,
        StDone = 2'd3
    } state_e;

    state_e             state_q;
    logic [width-1:0]   a_q;
    logic [width-1:0]   b_q;
    logic               op_q;
    logic [width-1:0]   result_q;
    logic               flag_q;
    logic               valid_q;
    logic               ld_s1_q;
    logic               ld_s2_q;
    logic               ld_s3_q;
    logic               ld_rise;
    logic               flag_calc;

    assign ld_rise = ld_s2_q & ~ld_s3_q;

    // SUB is A + ~B + 1, so the adder needs no knowledge of the operation.
    assign add_a    = a_q;
    assign add_b    = op_q ? ~b_q : b_q;
    assign add_c_in = op_q;

`ifdef ADD_SEQ_SIGNED_OVF_EN
    logic unused_in;
    assign unused_in = ^{add_overflow, add_out[width-2:0]};
    assign flag_calc = (add_a[width-1] == add_b[width-1]) & (add_out[width-1] != add_a[width-1]);
`else
    // Carry out inverted for SUB gives the borrow (A < B unsigned).
    assign flag_calc = add_overflow ^ op_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StA;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 1'b0;
            result_q <= '0;
            flag_q   <= 1'b0;
            valid_q  <= 1'b0;
            ld_s1_q  <= 1'b0;
            ld_s2_q  <= 1'b0;
            ld_s3_q  <= 1'b0;
        end else if (clear) begin
            // Clear wins over a coincident load pulse, which is dropped.
            state_q  <= StA;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 1'b0;
            result_q <= '0;
            flag_q   <= 1'b0;
            valid_q  <= 1'b0;
            ld_s1_q  <= 1'b0;
            ld_s2_q  <= 1'b0;
            ld_s3_q  <= 1'b0;
        end else begin
            ld_s1_q <= load;
            ld_s2_q <= ld_s1_q;
            ld_s3_q <= ld_s2_q;
            unique case (state_q)
                StA: begin
                    if (ld_rise) begin
                        a_q     <= sw;
                        state_q <= StB;
                    end
                end
                StB: begin
                    if (ld_rise) begin
                        b_q     <= sw;
                        op_q    <= op_sub;
                        state_q <= StCalc;
                    end
                end
                StCalc: begin
                    result_q <= add_out;
                    flag_q   <= flag_calc;
                    valid_q  <= 1'b1;
                    state_q  <= StDone;
                end
                StDone: begin
                    if (ld_rise) begin
                        a_q     <= sw;
                        valid_q <= 1'b0;
                        state_q <= StB;
                    end
                end
                default: state_q <= StA;
            endcase
        end
    end

    assign result       = result_q;
    assign flag         = flag_q;
    assign result_valid = valid_q;
    assign state        = state_q;

endmodule

// File: tb/tb_add_operand_seq.sv
// Directed, table-driven bench for add_operand_seq with a behavioural ripple-adder model.
module tb_add_operand_seq;

    localparam int unsigned W = 6;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] sw;
    logic         op_sub;
    logic         load;
    logic         clear;
    logic [W-1:0] add_a;
    logic [W-1:0] add_b;
    logic         add_c_in;
    logic [W-1:0] add_out;
    logic         add_overflow;
    logic [W-1:0] result;
    logic         flag;
    logic         result_valid;
    logic [1:0]   state;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Stand-in for the project1 ripple adder.
    assign {add_overflow, add_out} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_c_in};

    add_operand_seq #(.width(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sw           (sw),
        .op_sub       (op_sub),
        .load         (load),
        .clear        (clear),
        .add_a        (add_a),
        .add_b        (add_b),
        .add_c_in     (add_c_in),
        .add_out      (add_out),
        .add_overflow (add_overflow),
        .result       (result),
        .flag         (flag),
        .result_valid (result_valid),
        .state        (state)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         op;
        logic [W-1:0] exp_b_drv;
        logic [W-1:0] exp_res;
        logic         exp_flag_u;
        logic         exp_flag_s;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive one load press: capture happens on the 3rd rising edge after assertion.
    task automatic press(input logic [W-1:0] val, input logic op);
        @(negedge clk);
        sw     = val;
        op_sub = op;
        load   = 1'b1;
        repeat (4) @(negedge clk);
        load   = 1'b0;
        sw     = '0;
        op_sub = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_add_a"}, 32'(add_a), 32'd0);
        check({tag, "_add_b"}, 32'(add_b), 32'd0);
        check({tag, "_c_in"}, 32'(add_c_in), 32'd0);
        check({tag, "_result"}, 32'(result), 32'd0);
        check({tag, "_flag"}, 32'(flag), 32'd0);
        check({tag, "_valid"}, 32'(result_valid), 32'd0);
        check({tag, "_state"}, 32'(state), 32'd0);
    endtask

    initial begin
        //             a      b      op    add_b  result flag_u flag_s
        vecs[0] = '{6'd5,  6'd3,  1'b0, 6'd3,  6'd8,  1'b0, 1'b0};
        vecs[1] = '{6'd63, 6'd1,  1'b0, 6'd1,  6'd0,  1'b1, 1'b0};
        vecs[2] = '{6'd5,  6'd3,  1'b1, 6'h3C, 6'd2,  1'b0, 1'b0};
        vecs[3] = '{6'd3,  6'd5,  1'b1, 6'd58, 6'h3E, 1'b1, 1'b0};
        vecs[4] = '{6'd31, 6'd1,  1'b0, 6'd1,  6'd32, 1'b0, 1'b1};
        vecs[5] = '{6'd0,  6'd32, 1'b1, 6'd31, 6'd32, 1'b1, 1'b1};
        vecs[6] = '{6'd40, 6'd30, 1'b0, 6'd30, 6'd6,  1'b1, 1'b0};
        vecs[7] = '{6'd10, 6'd10, 1'b1, 6'd53, 6'd0,  1'b0, 1'b0};

        rst_n  = 1'b0;
        sw     = '0;
        op_sub = 1'b0;
        load   = 1'b0;
        clear  = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Load held high for 20 cycles: one capture only, later sw changes ignored.
        @(negedge clk);
        sw   = 6'd9;
        load = 1'b1;
        repeat (5) @(negedge clk);
        sw = 6'd44;
        repeat (15) @(negedge clk);
        check("hold_state", 32'(state), 32'd1);
        check("hold_add_a", 32'(add_a), 32'd9);
        load = 1'b0;
        repeat (3) @(negedge clk);
        check("hold_state_after", 32'(state), 32'd1);

        // Latency of the B capture, edge by edge.
        sw     = 6'd4;
        op_sub = 1'b0;
        load   = 1'b1;
        repeat (2) @(negedge clk);
        check("lat_e2_state", 32'(state), 32'd1);
        @(negedge clk);
        check("lat_e3_state", 32'(state), 32'd2);
        check("lat_e3_valid", 32'(result_valid), 32'd0);
        @(negedge clk);
        check("lat_e4_state", 32'(state), 32'd3);
        check("lat_e4_valid", 32'(result_valid), 32'd1);
        check("lat_result", 32'(result), 32'd13);
        load = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            press(vecs[i].a, 1'b0);
            check($sformatf("v%0d_a_state", i), 32'(state), 32'd1);
            check($sformatf("v%0d_a_valid", i), 32'(result_valid), 32'd0);
            check($sformatf("v%0d_add_a", i), 32'(add_a), 32'(vecs[i].a));
            press(vecs[i].b, vecs[i].op);
            check($sformatf("v%0d_add_b", i), 32'(add_b), 32'(vecs[i].exp_b_drv));
            check($sformatf("v%0d_c_in", i), 32'(add_c_in), 32'(vecs[i].op));
            check($sformatf("v%0d_result", i), 32'(result), 32'(vecs[i].exp_res));
`ifdef ADD_SEQ_SIGNED_OVF_EN
            check($sformatf("v%0d_flag", i), 32'(flag), 32'(vecs[i].exp_flag_s));
`else
            check($sformatf("v%0d_flag", i), 32'(flag), 32'(vecs[i].exp_flag_u));
`endif
            check($sformatf("v%0d_valid", i), 32'(result_valid), 32'd1);
            check($sformatf("v%0d_state", i), 32'(state), 32'd3);
        end

        // Chain from S_DONE with sw=7, then async reset mid-cycle while in S_B.
        press(6'd7, 1'b0);
        check("chain_add_a", 32'(add_a), 32'd7);
        check("chain_valid", 32'(result_valid), 32'd0);
        check("chain_state", 32'(state), 32'd1);
        check("chain_result_held", 32'(result), 32'd0);
        press(6'd20, 1'b0);
        check("pre_rst_result", 32'(result), 32'd27);
        press(6'd11, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        #1;
        rst_n = 1'b1;

        // Clear coincident with ld_rise in S_DONE.
        press(6'd12, 1'b0);
        press(6'd9, 1'b0);
        check("pre_clr_result", 32'(result), 32'd21);
        check("pre_clr_state", 32'(state), 32'd3);
        sw   = 6'd50;
        load = 1'b1;
        repeat (2) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        load  = 1'b0;
        check_reset_outputs("clear");
        repeat (5) @(negedge clk);
        check("post_clr_state", 32'(state), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
